// File: rtl/lt100_timer_resp_pkg.sv
// Shared lt100 peripheral definitions: register offsets, CTRL bits, responder FSM encodings.
package lt100_timer_resp_pkg;

    localparam logic [4:0] OFF_CTRL     = 5'h00;
    localparam logic [4:0] OFF_PRESCALE = 5'h04;
    localparam logic [4:0] OFF_COUNT    = 5'h08;
    localparam logic [4:0] OFF_COMPARE  = 5'h0C;
    localparam logic [4:0] OFF_STATUS   = 5'h10;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_IE       = 1;
    localparam int unsigned CTRL_AUTO_CLR = 2;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RESP     = 2'd1;
    localparam logic [1:0] ST_WAIT_LOW = 2'd2;

    function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/lt100_timer_resp_bus_fsm.sv
// lt100 bus target handshake: window decode, IDLE/RESP/WAIT_LOW sequencing, bus_err and
// registered read data. Reusable by every lt100 peripheral.
module lt100_timer_resp_bus_fsm
    import lt100_timer_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_4000,
    parameter int unsigned WIN_BITS  = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] rd_data,
    output logic        wr_stb,
    output logic        ready,
    output logic        bus_err,
    output logic [31:0] o_data
);

    logic [1:0]  state_q, state_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [31:0] data_q, data_d;
    logic        in_win, reg_ok, access;

    always_comb begin
        in_win = (addr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
        reg_ok = (addr[1:0] == 2'b00) && (32'(addr[WIN_BITS-1:0]) <= 32'(OFF_STATUS));
        access = (state_q == ST_IDLE) && enable && in_win;
        wr_stb = access && reg_ok && wr_en;

        state_d = state_q;
        ready_d = ready_q;
        err_d   = err_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    state_d = ST_RESP;
                    ready_d = 1'b1;
                    err_d   = !reg_ok;
                    data_d  = (reg_ok && !wr_en) ? rd_data : 32'h0;
                end
            end
            ST_RESP: state_d = ST_WAIT_LOW;
            ST_WAIT_LOW: begin
                // Stay here while enable is held so a level enable cannot re-trigger.
                if (!enable) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b0;
                    err_d   = 1'b0;
                    data_d  = 32'h0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b0;
                err_d   = 1'b0;
                data_d  = 32'h0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign ready   = ready_q;
    assign bus_err = err_q;
    assign o_data  = data_q;

endmodule

// File: rtl/lt100_timer_resp.sv
// lt100 bus responder: 32-bit prescaled timer with compare match, sticky MATCH and level irq.
module lt100_timer_resp
    import lt100_timer_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_4000,
    parameter int unsigned WIN_BITS  = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] i_data,
    input  logic [3:0]  be,
    output logic        ready,
    output logic [31:0] o_data,
    output logic        irq,
    output logic        bus_err
);

    logic [2:0]  ctrl_q, ctrl_d;
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] presc_cnt_q, presc_cnt_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        match_q, match_d;
    logic        irq_q;

    logic        wr_stb;
    logic [31:0] rd_data, count_inc, presc_merge;
    logic        wr_ctrl, wr_presc, wr_count, wr_cmp, wr_status;
    logic        tick, hit;

    lt100_timer_resp_bus_fsm #(
        .BASE_ADDR (BASE_ADDR),
        .WIN_BITS  (WIN_BITS)
    ) u_bus_fsm (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .wr_en   (wr_en),
        .addr    (addr),
        .rd_data (rd_data),
        .wr_stb  (wr_stb),
        .ready   (ready),
        .bus_err (bus_err),
        .o_data  (o_data)
    );

    always_comb begin
        rd_data = 32'h0;
        case (addr[4:0])
            OFF_CTRL:     rd_data = {29'h0, ctrl_q};
            OFF_PRESCALE: rd_data = {16'h0, prescale_q};
            OFF_COUNT:    rd_data = count_q;
            OFF_COMPARE:  rd_data = compare_q;
            OFF_STATUS:   rd_data = {31'h0, match_q};
            default:      rd_data = 32'h0;
        endcase
    end

    always_comb begin
        wr_ctrl   = wr_stb && (addr[4:0] == OFF_CTRL);
        wr_presc  = wr_stb && (addr[4:0] == OFF_PRESCALE);
        wr_count  = wr_stb && (addr[4:0] == OFF_COUNT);
        wr_cmp    = wr_stb && (addr[4:0] == OFF_COMPARE);
        wr_status = wr_stb && (addr[4:0] == OFF_STATUS);

        // Tick uses the pre-write EN, so a same-cycle EN=0 write still lets this tick land.
        tick      = ctrl_q[CTRL_EN] && (presc_cnt_q == prescale_q);
        count_inc = count_q + 32'd1;
        hit       = tick && (count_inc == compare_q);

        ctrl_d = ctrl_q;
        if (wr_ctrl && be[0]) ctrl_d = i_data[2:0];

        presc_merge = apply_be({16'h0, prescale_q}, i_data, be);
        prescale_d  = wr_presc ? presc_merge[15:0] : prescale_q;

        compare_d = wr_cmp ? apply_be(compare_q, i_data, be) : compare_q;

        presc_cnt_d = presc_cnt_q;
        if (ctrl_q[CTRL_EN]) presc_cnt_d = tick ? 16'h0 : presc_cnt_q + 16'd1;
        if (wr_count) presc_cnt_d = 16'h0;

        count_d = count_q;
        if (tick) count_d = (hit && ctrl_q[CTRL_AUTO_CLR]) ? 32'h0 : count_inc;
        if (wr_count) count_d = apply_be(count_q, i_data, be);

        match_d = match_q;
        if (wr_status && be[0] && i_data[0]) match_d = 1'b0;
        if (hit) match_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q      <= 3'h0;
            prescale_q  <= 16'h0;
            presc_cnt_q <= 16'h0;
            count_q     <= 32'h0;
            compare_q   <= 32'h0;
            match_q     <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            prescale_q  <= prescale_d;
            presc_cnt_q <= presc_cnt_d;
            count_q     <= count_d;
            compare_q   <= compare_d;
            match_q     <= match_d;
            irq_q       <= match_q & ctrl_q[CTRL_IE];
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_lt100_timer_resp.sv
// Directed-vector bench for lt100_timer_resp with hand-computed expected values.
module tb_lt100_timer_resp;

    localparam logic [31:0] BASE = 32'h0000_4000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] i_data = 32'h0;
    logic [3:0]  be = 4'h0;
    logic        ready;
    logic [31:0] o_data;
    logic        irq;
    logic        bus_err;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic        irq_at_resp;
    logic [31:0] rd;
    logic        err;

    lt100_timer_resp dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .wr_en   (wr_en),
        .addr    (addr),
        .i_data  (i_data),
        .be      (be),
        .ready   (ready),
        .o_data  (o_data),
        .irq     (irq),
        .bus_err (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access; hold = extra cycles enable stays high after ready. Returns 1 clk after IDLE.
    task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] b, input int hold,
                            output logic [31:0] rdata, output logic rerr);
        @(negedge clk);
        enable = 1'b1; wr_en = w; addr = a; i_data = d; be = b;
        @(posedge clk); #1;
        check_vec("ready_lat", ready, 1);
        rdata = o_data;
        rerr = bus_err;
        irq_at_resp = irq;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_vec("ready_hold", ready, 1);
        end
        @(negedge clk);
        enable = 1'b0; wr_en = 1'b0;
        if (hold == 0) @(posedge clk);
        @(posedge clk); #1;
        check_vec("ready_drop", ready, 0);
        check_vec("err_drop", bus_err, 0);
        check_vec("odata_drop", o_data, 0);
    endtask

    task automatic wr(input logic [4:0] off, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] r;
        logic        e;
        bus_xfer(1'b1, BASE + 32'(off), d, b, 0, r, e);
        check_vec("wr_err", e, 0);
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] off, input logic [31:0] exp);
        logic [31:0] r;
        logic        e;
        bus_xfer(1'b0, BASE + 32'(off), 32'h0, 4'hF, 0, r, e);
        check_vec(tag, r, exp);
        check_vec({tag, "_err"}, e, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_vec("rst_ready", ready, 0);
        check_vec("rst_odata", o_data, 0);
        check_vec("rst_irq", irq, 0);
        check_vec("rst_err", bus_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        rd_chk("rst_ctrl", 5'h00, 32'h0);
        rd_chk("rst_presc", 5'h04, 32'h0);
        rd_chk("rst_count", 5'h08, 32'h0);
        rd_chk("rst_cmp", 5'h0C, 32'h0);
        rd_chk("rst_status", 5'h10, 32'h0);

        // Compare match: ticks every clk, COUNT 0..5, MATCH at 5th tick, irq one clk later.
        wr(5'h0C, 32'd5, 4'hF);
        wr(5'h04, 32'd0, 4'hF);
        bus_xfer(1'b1, BASE, 32'h3, 4'hF, 0, rd, err);
        repeat (3) @(posedge clk);
        #1;
        check_vec("irq_early", irq, 0);
        @(posedge clk); #1;
        check_vec("irq_set", irq, 1);
        rd_chk("status_match", 5'h10, 32'h1);
        bus_xfer(1'b1, BASE + 32'h10, 32'h1, 4'h1, 0, rd, err);
        check_vec("irq_at_w1c", irq_at_resp, 1);
        check_vec("irq_cleared", irq, 0);
        rd_chk("status_clr", 5'h10, 32'h0);
        wr(5'h00, 32'h0, 4'hF);

        // Wrap: prescale 2 -> tick every 3 clk; FFFFFFFE -> FFFFFFFF -> 0.
        wr(5'h08, 32'hFFFF_FFFE, 4'hF);
        wr(5'h04, 32'd2, 4'hF);
        bus_xfer(1'b1, BASE, 32'h1, 4'hF, 0, rd, err);
        repeat (4) @(posedge clk);
        rd_chk("count_wrap", 5'h08, 32'h0);
        rd_chk("status_nowrap", 5'h10, 32'h0);
        wr(5'h00, 32'h0, 4'hF);

        // Byte enables.
        wr(5'h0C, 32'h0, 4'hF);
        wr(5'h0C, 32'hAABB_CCDD, 4'b0010);
        rd_chk("cmp_be", 5'h0C, 32'h0000_CC00);

        // AUTO_CLR: COMPARE=2 -> COUNT 1,0,1; stopped on the third tick (EN=0 write still ticks).
        wr(5'h04, 32'd0, 4'hF);
        wr(5'h0C, 32'd2, 4'hF);
        wr(5'h08, 32'd0, 4'hF);
        wr(5'h00, 32'h5, 4'hF);
        wr(5'h00, 32'h0, 4'hF);
        rd_chk("autoclr_count", 5'h08, 32'h1);
        rd_chk("autoclr_match", 5'h10, 32'h1);

        // Unmapped and misaligned accesses.
        bus_xfer(1'b1, BASE + 32'h14, 32'hFFFF_FFFF, 4'hF, 0, rd, err);
        check_vec("unmap_wr_err", err, 1);
        check_vec("unmap_wr_data", rd, 0);
        bus_xfer(1'b0, BASE + 32'h14, 32'h0, 4'hF, 0, rd, err);
        check_vec("unmap_rd_err", err, 1);
        check_vec("unmap_rd_data", rd, 0);
        bus_xfer(1'b1, BASE + 32'h2, 32'hFFFF_FFFF, 4'hF, 0, rd, err);
        check_vec("misal_err", err, 1);
        rd_chk("misal_ctrl", 5'h00, 32'h0);

        // Out of window: never answered, no write.
        @(negedge clk);
        enable = 1'b1; wr_en = 1'b1; addr = 32'h0000_5008; i_data = 32'hDEAD; be = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_vec("oow_ready", ready, 0);
        end
        @(negedge clk);
        enable = 1'b0; wr_en = 1'b0;
        rd_chk("oow_count", 5'h08, 32'h1);

        // Enable held 10 cycles after ready.
        bus_xfer(1'b1, BASE + 32'h4, 32'h0000_00AB, 4'hF, 10, rd, err);
        check_vec("hold_err", err, 0);
        rd_chk("hold_presc", 5'h04, 32'h0000_00AB);

        // Reset pulse while in RESP.
        @(negedge clk);
        enable = 1'b1; wr_en = 1'b1; addr = BASE + 32'hC; i_data = 32'h77; be = 4'hF;
        @(posedge clk); #1;
        check_vec("rstp_ready1", ready, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_vec("rstp_ready0", ready, 0);
        check_vec("rstp_odata", o_data, 0);
        @(negedge clk);
        rst_n = 1'b1; enable = 1'b0; wr_en = 1'b0;
        rd_chk("rstp_cmp", 5'h0C, 32'h0);
        rd_chk("rstp_presc", 5'h04, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
